// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the NoC simulator run controller.
`ifndef TS_WIDTH
`define TS_WIDTH 10
`endif

package sim_ctrl_pkg;

    localparam int unsigned SIM_TS_WIDTH = `TS_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_CFG,
        ST_RUN,
        ST_DRAIN,
        ST_STATS,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SIM     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/sim_quiesce_det.sv
// Drain monitor: consecutive-quiescent counter plus a saturating drain timeout timer.
module sim_quiesce_det #(
    parameter int unsigned QUIESCE_CYCLES = 8,
    parameter int unsigned DRAIN_TIMEOUT  = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic quiescent,
    output logic quiesced,
    output logic timeout
);

    localparam int unsigned QW = $clog2(QUIESCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(QUIESCE_CYCLES - 1);
    localparam logic [QW-1:0] Q_MAX  = QW'(QUIESCE_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(DRAIN_TIMEOUT);

    logic [QW-1:0] q_cnt;
    logic [TW-1:0] timer;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            q_cnt <= '0;
            timer <= '0;
        end else begin
            if (!quiescent) begin
                q_cnt <= '0;
            end else if (q_cnt != Q_MAX) begin
                q_cnt <= q_cnt + 1'b1;
            end
            if (timer != T_MAX) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Both flags fire in the cycle that completes the count, so the FSM leaves on that edge.
    always_comb begin
        quiesced = quiescent && (q_cnt >= Q_LAST);
        timeout  = (timer >= T_LAST);
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run sequencer for the 9-node NoC simulator: reset, config load, timed run, drain, stats unload.
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned CONFIG_WORDS   = 64,
    parameter int unsigned STATS_WORDS    = 32,
    parameter int unsigned TS_WIDTH       = SIM_TS_WIDTH,
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned QUIESCE_CYCLES = 8,
    parameter int unsigned DRAIN_TIMEOUT  = 4096
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [TS_WIDTH-1:0] run_ticks,
    input  logic [15:0]         cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [15:0]         stats_data,
    output logic                stats_valid,
    input  logic                stats_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic                sim_reset,
    output logic                sim_enable,
    output logic                sim_stop_injection,
    output logic [15:0]         sim_config_in,
    output logic                sim_config_in_valid,
    output logic                sim_stats_shift,
    input  logic [15:0]         sim_stats_out,
    input  logic                sim_quiescent,
    input  logic                sim_time_tick,
    input  logic                sim_error
);

    localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned CW = $clog2(CONFIG_WORDS + 1);
    localparam int unsigned SW = $clog2(STATS_WORDS + 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] CFG_LAST = CW'(CONFIG_WORDS - 1);
    localparam logic [SW-1:0] STS_LAST = SW'(STATS_WORDS - 1);

    state_t              state, state_nx;
    logic [TS_WIDTH-1:0] run_ticks_q;
    logic [TS_WIDTH-1:0] tick_cnt;
    logic [RW-1:0]       rst_cnt;
    logic [CW-1:0]       cfg_cnt;
    logic [SW-1:0]       stats_cnt;
    logic [1:0]          err_code_q;
    logic [15:0]         cfg_word_q;
    logic                cfg_valid_q;
    logic                shift_d;
    logic                start_ok, cfg_fire, stats_fire, tick_hit;
    logic                quiesced, drain_timeout;

    sim_quiesce_det #(
        .QUIESCE_CYCLES (QUIESCE_CYCLES),
        .DRAIN_TIMEOUT  (DRAIN_TIMEOUT)
    ) u_quiesce_det (
        .clock     (clock),
        .reset     (reset),
        .clear     (state != ST_DRAIN),
        .quiescent (sim_quiescent),
        .quiesced  (quiesced),
        .timeout   (drain_timeout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            run_ticks_q <= '0;
            tick_cnt    <= '0;
            rst_cnt     <= '0;
            cfg_cnt     <= '0;
            stats_cnt   <= '0;
            err_code_q  <= ERR_NONE;
            cfg_word_q  <= '0;
            cfg_valid_q <= 1'b0;
            shift_d     <= 1'b0;
        end else begin
            state       <= state_nx;
            cfg_valid_q <= cfg_fire;
            shift_d     <= sim_stats_shift;
            rst_cnt     <= (state == ST_RST) ? rst_cnt + 1'b1 : '0;
            if (cfg_fire) begin
                cfg_word_q <= cfg_data;
            end
            if (start_ok) begin
                run_ticks_q <= run_ticks;
                tick_cnt    <= '0;
                cfg_cnt     <= '0;
                stats_cnt   <= '0;
                err_code_q  <= ERR_NONE;
            end else begin
                if (cfg_fire) begin
                    cfg_cnt <= cfg_cnt + 1'b1;
                end
                if (state == ST_RUN && sim_time_tick && tick_cnt != '1) begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
                if (stats_fire) begin
                    stats_cnt <= stats_cnt + 1'b1;
                end
                if ((state == ST_RUN || state == ST_DRAIN) && state_nx == ST_ERR) begin
                    err_code_q <= sim_error ? ERR_SIM : ERR_TIMEOUT;
                end
            end
        end
    end

    always_comb begin
        state_nx            = state;
        busy                = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
        done                = (state == ST_DONE);
        err                 = (state == ST_ERR);
        err_code            = err_code_q;
        cfg_ready           = (state == ST_CFG);
        sim_reset           = (state == ST_RST);
        sim_enable          = (state == ST_RUN) || (state == ST_DRAIN);
        sim_stop_injection  = (state == ST_DRAIN);
        sim_config_in       = cfg_word_q;
        sim_config_in_valid = cfg_valid_q;
        // One bubble after each shift lets the chain head settle before it is offered again.
        stats_valid         = (state == ST_STATS) && !shift_d;
        stats_data          = (state == ST_STATS) ? sim_stats_out : '0;
        sim_stats_shift     = stats_valid && stats_ready;
        start_ok            = start && !busy;
        cfg_fire            = cfg_ready && cfg_valid;
        stats_fire          = sim_stats_shift;
        tick_hit            = sim_time_tick && ((tick_cnt + 1'b1) == run_ticks_q);

        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_nx = ST_RST;
            end
            ST_RST: begin
                if (rst_cnt == RST_LAST) state_nx = ST_CFG;
            end
            ST_CFG: begin
                if (cfg_fire && cfg_cnt == CFG_LAST) begin
                    state_nx = (run_ticks_q == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (sim_error)     state_nx = ST_ERR;
                else if (tick_hit) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (sim_error)          state_nx = ST_ERR;
                else if (quiesced)      state_nx = ST_STATS;
                else if (drain_timeout) state_nx = ST_ERR;
            end
            ST_STATS: begin
                if (stats_fire && stats_cnt == STS_LAST) state_nx = ST_DONE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl with a reactive simulator model and scoreboards.
module tb_sim_run_ctrl;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [9:0]  run_ticks;
    logic [15:0] cfg_data;
    logic        cfg_valid, cfg_ready;
    logic [15:0] stats_data;
    logic        stats_valid, stats_ready;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic        sim_reset, sim_enable, sim_stop_injection;
    logic [15:0] sim_config_in;
    logic        sim_config_in_valid, sim_stats_shift;
    logic [15:0] sim_stats_out;
    logic        sim_quiescent, sim_time_tick, sim_error;

    int checks = 0;
    int passed = 0;

    logic [15:0] cfg_sent[$], got_cfg[$], chain[$], exp_stats[$], got_stats[$];
    int n_rst, rst_last, last_cfg_pulse_cyc, run_first_cyc, run_ticks_seen, run_cycles;
    int drain_cyc, drain_exp, stats_cycles, shift_cnt, shift_viol, bubble_viol, hold_viol;
    int data_viol, en_drain_viol, err_drive_cyc, err_rise_cyc, cfg_bad, stats_bad;
    bit last_run_tick, en_at_err, stop_at_err, timed_out, fin_done, fin_err;
    logic [1:0] fin_code;

    always #5 clock = ~clock;

    sim_run_ctrl dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .run_ticks           (run_ticks),
        .cfg_data            (cfg_data),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .stats_data          (stats_data),
        .stats_valid         (stats_valid),
        .stats_ready         (stats_ready),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .err_code            (err_code),
        .sim_reset           (sim_reset),
        .sim_enable          (sim_enable),
        .sim_stop_injection  (sim_stop_injection),
        .sim_config_in       (sim_config_in),
        .sim_config_in_valid (sim_config_in_valid),
        .sim_stats_shift     (sim_stats_shift),
        .sim_stats_out       (sim_stats_out),
        .sim_quiescent       (sim_quiescent),
        .sim_time_tick       (sim_time_tick),
        .sim_error           (sim_error)
    );

    function automatic logic [43:0] outs();
        return {busy, done, err, err_code, sim_reset, sim_enable, sim_stop_injection,
                sim_config_in, sim_config_in_valid, sim_stats_shift, cfg_ready,
                stats_valid, stats_data};
    endfunction

    // Drives one complete run, playing the simulator and host, and records what was observed.
    task automatic do_run(input int rt, input int cfg_mode, input int q_mode, input int sr_mode,
                          input int err_at, input bit busy_start);
        int cfg_idx, run_tick_drv, streak, low_done;
        bit in_run, in_drain, in_stats, drain_seen, prev_shift, prev_hold, bs_done;
        logic [15:0] hold_word, w;
        cfg_sent.delete(); chain.delete(); exp_stats.delete(); got_cfg.delete(); got_stats.delete();
        for (int i = 0; i < 64; i++) cfg_sent.push_back(cfg_mode == 0 ? 16'(i) : 16'($urandom));
        for (int i = 0; i < 32; i++) begin
            w = 16'($urandom);
            chain.push_back(w);
            exp_stats.push_back(w);
        end
        n_rst = 0; rst_last = -1; last_cfg_pulse_cyc = -1; run_first_cyc = -1;
        run_ticks_seen = 0; run_cycles = 0; last_run_tick = 0; drain_cyc = 0; drain_exp = -1;
        stats_cycles = 0; shift_cnt = 0; shift_viol = 0; bubble_viol = 0; hold_viol = 0;
        data_viol = 0; en_drain_viol = 0; err_drive_cyc = -1; err_rise_cyc = -1;
        en_at_err = 1; stop_at_err = 1; timed_out = 1;
        cfg_idx = 0; run_tick_drv = 0; streak = 0; low_done = 0;
        drain_seen = 0; prev_shift = 0; prev_hold = 0; bs_done = 0; hold_word = '0;

        @(negedge clock);
        reset = 0; start = 1; run_ticks = 10'(rt);
        cfg_valid = 0; cfg_data = '0; stats_ready = 0; sim_quiescent = 0;
        sim_time_tick = 0; sim_error = 0; sim_stats_out = '0;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge clock);
            start    = 0;
            in_run   = sim_enable && !sim_stop_injection;
            in_drain = sim_stop_injection;
            in_stats = drain_seen && busy && !sim_stop_injection;
            if (busy_start && !bs_done && cfg_idx == 30 && cfg_ready) begin
                start = 1; run_ticks = 10'(rt + 3); bs_done = 1;
            end
            case (cfg_mode)
                0:       cfg_valid = (cfg_idx < 64);
                1:       cfg_valid = (cfg_idx < 64) && (cyc % 2 == 0);
                default: cfg_valid = (cfg_idx < 64) && ($urandom_range(0, 1) == 1);
            endcase
            cfg_data = (cfg_idx < 64) ? cfg_sent[cfg_idx] : 16'hFFFF;
            sim_time_tick = in_run ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            sim_error = 0;
            if (in_run && sim_time_tick) begin
                run_tick_drv++;
                if (err_at > 0 && run_tick_drv == err_at) begin
                    sim_error = 1; err_drive_cyc = cyc;
                end
            end
            if (!in_drain) sim_quiescent = $urandom_range(0, 1) == 1;
            else case (q_mode)
                0:       sim_quiescent = 1;
                1:       sim_quiescent = 0;
                2:       sim_quiescent = (drain_cyc != 7);
                default: sim_quiescent = ($urandom_range(0, 3) != 0);
            endcase
            case (sr_mode)
                0: stats_ready = 1;
                1: begin
                    stats_ready = 1;
                    if (in_stats && got_stats.size() >= 10 && low_done < 10) begin
                        stats_ready = 0; low_done++;
                    end
                end
                default: stats_ready = ($urandom_range(0, 2) != 0);
            endcase
            sim_stats_out = (chain.size() > 0) ? chain[0] : 16'hDEAD;
            #2;
            if (sim_reset) begin n_rst++; rst_last = cyc; end
            if (sim_config_in_valid) begin got_cfg.push_back(sim_config_in); last_cfg_pulse_cyc = cyc; end
            if (cfg_valid && cfg_ready) cfg_idx++;
            if (in_run) begin
                run_cycles++;
                if (run_first_cyc < 0) run_first_cyc = cyc;
                if (sim_time_tick) run_ticks_seen++;
                last_run_tick = sim_time_tick;
            end
            if (in_drain) begin
                drain_seen = 1; drain_cyc++;
                streak = sim_quiescent ? streak + 1 : 0;
                if (streak == 8 && drain_exp < 0) drain_exp = drain_cyc;
                if (!sim_enable) en_drain_viol++;
            end
            if (in_stats) begin
                stats_cycles++;
                if (stats_valid == prev_shift) bubble_viol++;
                if (sim_stats_shift !== (stats_valid && stats_ready)) shift_viol++;
                if (stats_valid && stats_data !== sim_stats_out) data_viol++;
                if (prev_hold && (!stats_valid || stats_data !== hold_word)) hold_viol++;
                if (stats_valid && stats_ready) got_stats.push_back(stats_data);
                prev_hold  = stats_valid && !stats_ready;
                hold_word  = stats_data;
                prev_shift = sim_stats_shift;
            end else if (sim_stats_shift) begin
                shift_viol++;
            end
            if (sim_stats_shift) begin
                shift_cnt++;
                if (chain.size() > 0) void'(chain.pop_front());
            end
            if (err && err_rise_cyc < 0) begin
                err_rise_cyc = cyc; en_at_err = sim_enable; stop_at_err = sim_stop_injection;
            end
            if (done || err) begin timed_out = 0; break; end
        end
        if (drain_exp < 0) drain_exp = 4096;
        if (got_cfg.size() != 64) cfg_bad = 1000 + got_cfg.size();
        else begin
            cfg_bad = 0;
            foreach (got_cfg[i]) if (got_cfg[i] !== cfg_sent[i]) cfg_bad++;
        end
        if (got_stats.size() != 32) stats_bad = 1000 + got_stats.size();
        else begin
            stats_bad = 0;
            foreach (got_stats[i]) if (got_stats[i] !== exp_stats[i]) stats_bad++;
        end
        fin_done = done; fin_err = err; fin_code = err_code;
    endtask

    task automatic test_reset();
        reset = 1; start = 1; run_ticks = 10'd7; cfg_valid = 1; cfg_data = 16'h1234;
        stats_ready = 1; sim_stats_out = 16'hBEEF; sim_quiescent = 1; sim_time_tick = 1; sim_error = 1;
        repeat (3) @(negedge clock);
        #2;
        checks++;
        if (outs() !== '0) $display("FAIL reset_held: outputs %h want 0", outs());
        else passed++;
        @(negedge clock);
        reset = 0; start = 0; sim_error = 0;
        #2;
        checks++;
        if (outs() !== '0) $display("FAIL reset_idle: outputs %h want 0", outs());
        else passed++;
    endtask

    task automatic test_nominal();
        do_run(5, 0, 0, 0, 0, 0);
        checks++; if (timed_out) $display("FAIL nom_timeout: run did not finish"); else passed++;
        checks++; if (n_rst !== 4 || rst_last !== 3) $display("FAIL nom_rst: cycles %0d last %0d want 4/3", n_rst, rst_last); else passed++;
        checks++; if (cfg_bad !== 0) $display("FAIL nom_cfg: bad %0d want 0", cfg_bad); else passed++;
        checks++; if (run_ticks_seen !== 5 || !last_run_tick) $display("FAIL nom_ticks: %0d last %0d want 5/1", run_ticks_seen, last_run_tick); else passed++;
        checks++; if (drain_cyc !== 8 || en_drain_viol !== 0) $display("FAIL nom_drain: %0d en_viol %0d want 8/0", drain_cyc, en_drain_viol); else passed++;
        checks++; if (stats_bad !== 0 || shift_cnt !== 32) $display("FAIL nom_stats: bad %0d shifts %0d want 0/32", stats_bad, shift_cnt); else passed++;
        checks++; if (stats_cycles !== 63 || bubble_viol !== 0) $display("FAIL nom_rate: cycles %0d bubble %0d want 63/0", stats_cycles, bubble_viol); else passed++;
        checks++; if (!fin_done || fin_err || fin_code !== 2'b00) $display("FAIL nom_end: done %0d err %0d code %0d want 1/0/0", fin_done, fin_err, fin_code); else passed++;
    endtask

    task automatic test_cfg_backpressure();
        do_run(int'($urandom_range(1, 8)), 1, 0, 0, 0, 0);
        checks++; if (cfg_bad !== 0) $display("FAIL bp_cfg: bad %0d want 0", cfg_bad); else passed++;
        checks++; if (run_first_cyc !== last_cfg_pulse_cyc) $display("FAIL bp_run_entry: run %0d last cfg %0d", run_first_cyc, last_cfg_pulse_cyc); else passed++;
        checks++; if (!fin_done || timed_out) $display("FAIL bp_end: done %0d want 1", fin_done); else passed++;
    endtask

    task automatic test_sim_error();
        do_run(10, 0, 0, 0, 3, 0);
        checks++; if (err_rise_cyc !== err_drive_cyc + 1 || err_drive_cyc < 0) $display("FAIL err_latency: rise %0d drive %0d", err_rise_cyc, err_drive_cyc); else passed++;
        checks++; if (!fin_err || fin_code !== 2'b01) $display("FAIL err_code: err %0d code %0d want 1/1", fin_err, fin_code); else passed++;
        checks++; if (en_at_err || stop_at_err) $display("FAIL err_enable: en %0d stop %0d want 0/0", en_at_err, stop_at_err); else passed++;
        checks++; if (run_ticks_seen !== 3) $display("FAIL err_ticks: %0d want 3", run_ticks_seen); else passed++;
        do_run(4, 0, 0, 0, 0, 0);
        checks++; if (n_rst !== 4 || !fin_done || fin_code !== 2'b00) $display("FAIL err_restart: rst %0d done %0d code %0d", n_rst, fin_done, fin_code); else passed++;
    endtask

    task automatic test_drain_timeout();
        do_run(2, 0, 1, 0, 0, 0);
        checks++; if (drain_cyc !== 4096) $display("FAIL to_cycles: %0d want 4096", drain_cyc); else passed++;
        checks++; if (!fin_err || fin_code !== 2'b10) $display("FAIL to_code: err %0d code %0d want 1/2", fin_err, fin_code); else passed++;
        do_run(3, 0, 2, 0, 0, 0);
        checks++; if (drain_cyc !== 16) $display("FAIL q_pattern: drain %0d want 16", drain_cyc); else passed++;
        checks++; if (!fin_done || stats_bad !== 0) $display("FAIL q_pattern_end: done %0d bad %0d", fin_done, stats_bad); else passed++;
    endtask

    task automatic test_stats_backpressure();
        do_run(3, 0, 0, 1, 0, 0);
        checks++; if (stats_bad !== 0) $display("FAIL sbp_order: bad %0d want 0", stats_bad); else passed++;
        checks++; if (shift_viol !== 0 || shift_cnt !== 32) $display("FAIL sbp_shift: viol %0d shifts %0d want 0/32", shift_viol, shift_cnt); else passed++;
        checks++; if (hold_viol !== 0 || data_viol !== 0) $display("FAIL sbp_stable: hold %0d data %0d want 0/0", hold_viol, data_viol); else passed++;
        checks++; if (stats_cycles !== 72) $display("FAIL sbp_cycles: %0d want 72", stats_cycles); else passed++;
    endtask

    task automatic test_edge_cases();
        int seen;
        seen = 0;
        @(negedge clock);
        start = 1; run_ticks = 10'd5; cfg_valid = 0;
        @(negedge clock);
        start = 0;
        for (int i = 0; i < 40 && seen < 20; i++) begin
            @(negedge clock);
            cfg_valid = 1; cfg_data = 16'h00A5 + 16'(seen);
            if (cfg_ready) seen++;
        end
        reset = 1;
        @(negedge clock);
        reset = 0;
        #2;
        checks++;
        if (seen !== 20 || outs() !== '0) $display("FAIL mid_cfg_reset: words %0d outputs %h want 20/0", seen, outs());
        else passed++;
        cfg_valid = 0;
        do_run(0, 0, 0, 0, 0, 0);
        checks++; if (run_cycles !== 0 || drain_cyc !== 8) $display("FAIL zero_ticks: run %0d drain %0d want 0/8", run_cycles, drain_cyc); else passed++;
        checks++; if (!fin_done || cfg_bad !== 0) $display("FAIL zero_end: done %0d cfg %0d", fin_done, cfg_bad); else passed++;
        do_run(4, 0, 0, 0, 0, 1);
        checks++; if (n_rst !== 4 || cfg_bad !== 0 || run_ticks_seen !== 4) $display("FAIL busy_start: rst %0d cfg %0d ticks %0d", n_rst, cfg_bad, run_ticks_seen); else passed++;
    endtask

    task automatic test_random_runs();
        int rt;
        for (int k = 0; k < 4; k++) begin
            rt = int'($urandom_range(0, 15));
            do_run(rt, 2, 3, 2, 0, 0);
            checks++; if (cfg_bad !== 0 || run_ticks_seen !== rt) $display("FAIL rnd%0d_cfg_ticks: cfg %0d ticks %0d want 0/%0d", k, cfg_bad, run_ticks_seen, rt); else passed++;
            checks++; if (drain_cyc !== drain_exp) $display("FAIL rnd%0d_drain: %0d want %0d", k, drain_cyc, drain_exp); else passed++;
            checks++; if (stats_bad !== 0 || shift_viol !== 0 || bubble_viol !== 0 || hold_viol !== 0 || data_viol !== 0)
                $display("FAIL rnd%0d_stats: bad %0d shift %0d bubble %0d hold %0d data %0d", k, stats_bad, shift_viol, bubble_viol, hold_viol, data_viol);
            else passed++;
            checks++; if (drain_exp < 4096 && !fin_done) $display("FAIL rnd%0d_end: done %0d want 1", k, fin_done);
            else if (drain_exp >= 4096 && fin_code !== 2'b10) $display("FAIL rnd%0d_end: code %0d want 2", k, fin_code);
            else passed++;
        end
    endtask

    initial begin
        reset = 1; start = 0; run_ticks = '0; cfg_data = '0; cfg_valid = 0; stats_ready = 0;
        sim_stats_out = '0; sim_quiescent = 0; sim_time_tick = 0; sim_error = 0;
        test_reset();
        test_nominal();
        test_cfg_backpressure();
        test_sim_error();
        test_drain_timeout();
        test_stats_backpressure();
        test_edge_cases();
        test_random_runs();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
